// File: rtl/state_dump_engine_pkg.sv
// Shared encodings for the state dump engine: record kinds and FSM states.
package state_dump_pkg;

  localparam logic [1:0] KIND_HDR = 2'd0;
  localparam logic [1:0] KIND_REG = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;
  localparam logic [1:0] KIND_TRL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REG,
    S_MEM,
    S_TRL
  } state_t;

endpackage

// File: rtl/state_dump_engine_if.sv
// Read port into regfile/memory plus the valid/ready record stream of the dump engine.
interface state_dump_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) ();

  logic              rd_sel;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_kind;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output rd_sel, rd_addr, out_valid, out_kind, out_idx, out_data, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_sel, rd_addr, out_valid, out_kind, out_idx, out_data, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/state_dump_engine_dump_out_stage.sv
// Output record register: loads when empty or when the sink takes the current record.
module dump_out_stage
  import state_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [1:0]        in_kind,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              load_en,
  output logic              out_valid,
  output logic [1:0]        out_kind,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  assign load_en = !out_valid || out_ready;

  // A load with push=0 drains the register; payload is kept so idle outputs stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_kind  <= KIND_HDR;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load_en) begin
      out_valid <= push;
      if (push) begin
        out_kind <= in_kind;
        out_idx  <= in_idx;
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/state_dump_engine.sv
// Snapshot engine: freezes the core and streams header, regfile, memory and trailer records.
// Optional SKIP_ZERO_EN: entries reading zero are not emitted (index still advances).
module state_dump_engine
  import state_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int MEM_N  = 32,
  parameter int IDX_W  = 8,
  parameter int TS_W   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic hold,
  output logic busy,
  output logic overrun,
  state_dump_if.master dif
);

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] rec_q;
  logic [IDX_W-1:0]  idx_q;

  logic              load_en, reg_ph, mem_ph, idx_end, trl_in, trl_hs, acc, entry_ok;
  logic              push, ld_last;
  logic [1:0]        ld_kind;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;

  logic              o_vld, o_last;
  logic [1:0]        o_kind;
  logic [IDX_W-1:0]  o_idx;
  logic [DATA_W-1:0] o_data;

  // HDR state already has the header in the output register; next load is REG entry 0.
  assign reg_ph  = (state_q == S_HDR) || (state_q == S_REG);
  assign mem_ph  = (state_q == S_MEM);
  assign idx_end = reg_ph ? (idx_q == IDX_W'(REG_N - 1)) : (idx_q == IDX_W'(MEM_N - 1));
  assign trl_in  = (state_q == S_TRL) && o_vld && o_last;
  assign trl_hs  = trl_in && dif.out_ready;
  assign acc     = start && ((state_q == S_IDLE) || trl_hs);

`ifdef SKIP_ZERO_EN
  assign entry_ok = (dif.rd_data != '0);
`else
  assign entry_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start)   state_d = S_HDR;
      S_HDR, S_REG: if (load_en) state_d = idx_end ? S_MEM : S_REG;
      S_MEM:        if (load_en && idx_end) state_d = S_TRL;
      S_TRL:        if (trl_hs)  state_d = start ? S_HDR : S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push    = 1'b0;
    ld_kind = KIND_HDR;
    ld_idx  = '0;
    ld_data = '0;
    ld_last = 1'b0;
    if (acc) begin
      push    = 1'b1;
      ld_data = DATA_W'(ts_q);
    end else if (reg_ph || mem_ph) begin
      push    = entry_ok;
      ld_kind = mem_ph ? KIND_MEM : KIND_REG;
      ld_idx  = idx_q;
      ld_data = dif.rd_data;
    end else if ((state_q == S_TRL) && !trl_in) begin
      push    = 1'b1;
      ld_kind = KIND_TRL;
      ld_data = rec_q;
      ld_last = 1'b1;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign hold        = busy;
  assign dif.rd_sel  = mem_ph;
  assign dif.rd_addr = idx_q;

  // rec_q counts records already loaded, header included; it becomes the trailer payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      idx_q   <= '0;
      rec_q   <= '0;
      overrun <= 1'b0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (start && busy && !trl_hs) overrun <= 1'b1;
      if (acc) begin
        idx_q <= '0;
        rec_q <= DATA_W'(1);
      end else if ((reg_ph || mem_ph) && load_en) begin
        idx_q <= idx_end ? '0 : idx_q + 1'b1;
        if (push && (rec_q != '1)) rec_q <= rec_q + 1'b1;
      end
    end
  end

  dump_out_stage #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .in_kind   (ld_kind),
    .in_idx    (ld_idx),
    .in_data   (ld_data),
    .in_last   (ld_last),
    .out_ready (dif.out_ready),
    .load_en   (load_en),
    .out_valid (o_vld),
    .out_kind  (o_kind),
    .out_idx   (o_idx),
    .out_data  (o_data),
    .out_last  (o_last)
  );

  assign dif.out_valid = o_vld;
  assign dif.out_kind  = o_kind;
  assign dif.out_idx   = o_idx;
  assign dif.out_data  = o_data;
  assign dif.out_last  = o_last;

endmodule

// File: tb/tb_state_dump_engine.sv
// Random-stimulus bench for state_dump_engine against a record-queue reference model.
module tb_state_dump_engine;
  import state_dump_pkg::*;

  localparam int DATA_W   = 32;
  localparam int REG_N    = 32;
  localparam int MEM_N    = 32;
  localparam int IDX_W    = 8;
  localparam int TS_W     = 8;
  localparam int TSM      = 1 << TS_W;
  localparam int DUMP_CYC = 2 + REG_N + MEM_N;
`ifdef SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]        kind;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold, busy, overrun;

  state_dump_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dif ();

  state_dump_engine #(
    .DATA_W (DATA_W), .REG_N (REG_N), .MEM_N (MEM_N), .IDX_W (IDX_W), .TS_W (TS_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hold    (hold),
    .busy    (busy),
    .overrun (overrun),
    .dif     (dif)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] regs [REG_N];
  logic [DATA_W-1:0] mem  [MEM_N];

  always_comb begin
    dif.rd_data = '0;
    if (!dif.rd_sel && int'(dif.rd_addr) < REG_N)      dif.rd_data = regs[int'(dif.rd_addr)];
    else if (dif.rd_sel && int'(dif.rd_addr) < MEM_N)  dif.rd_data = mem[int'(dif.rd_addr)];
  end

  int   n_tot = 0;
  int   n_bad = 0;
  rec_t exp_q [$];
  bit   m_busy = 0, m_ovr = 0, mon_en = 0, after_rst = 1, rdy_all = 0;
  int   m_cnt = 0, cyc = 0, acc_cyc = 0, rmode = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] k, input int i, input logic [DATA_W-1:0] d,
                              input bit l);
    rec_t r;
    r.kind = k;
    r.idx  = i[IDX_W-1:0];
    r.data = d;
    r.last = l;
    return r;
  endfunction

  // Expected record stream for one dump, taken from the array contents at acceptance.
  task automatic build(input int ts);
    int n = 1;
    exp_q.push_back(mk(KIND_HDR, 0, ts, 1'b0));
    for (int i = 0; i < REG_N; i++)
      if (!SKIP || regs[i] != 0) begin exp_q.push_back(mk(KIND_REG, i, regs[i], 1'b0)); n++; end
    for (int i = 0; i < MEM_N; i++)
      if (!SKIP || mem[i] != 0) begin exp_q.push_back(mk(KIND_MEM, i, mem[i], 1'b0)); n++; end
    exp_q.push_back(mk(KIND_TRL, 0, n, 1'b1));
  endtask

  always @(negedge clk) begin
    rec_t got;
    bit   pop_trl;
    if (mon_en) begin
      cyc++;
      got = {dif.out_kind, dif.out_idx, dif.out_data, dif.out_last};
      if (after_rst)
        chk("rst_clear", 64'({dif.out_valid, got, dif.rd_sel, dif.rd_addr}), 64'(0));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("hold", 64'(hold), 64'(m_busy));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      pop_trl = 1'b0;
      if (exp_q.size() == 0) chk("idle_valid", 64'(dif.out_valid), 64'(0));
      else if (dif.out_valid) begin
        chk("record", 64'(got), 64'(exp_q[0]));
        if (dif.out_ready) begin
          pop_trl = exp_q[0].last;
          void'(exp_q.pop_front());
        end
      end
      if (m_busy && !dif.out_ready) rdy_all = 1'b0;
      if (pop_trl) begin
        m_busy = 1'b0;
        if (rdy_all) chk("dump_cycles", 64'(cyc - acc_cyc), 64'(DUMP_CYC));
      end
      if (rst) begin
        exp_q.delete();
        m_busy = 1'b0;
        m_ovr  = 1'b0;
      end else if (start) begin
        if (m_busy) m_ovr = 1'b1;
        else begin
          build(m_cnt);
          m_busy  = 1'b1;
          acc_cyc = cyc;
          rdy_all = 1'b1;
        end
      end
      after_rst = rst;
    end
    m_cnt = rst ? 0 : (m_cnt + 1) % TSM;
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (rmode)
      0:       dif.out_ready = 1'b1;
      1:       dif.out_ready = (cyc % 3) != 1;
      default: dif.out_ready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((m_busy || exp_q.size() != 0) && n < 2000) begin step(); n++; end
    chk(tag, 64'(n < 2000), 64'(1));
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (m_cnt != v && n < 600) begin step(); n++; end
    chk("cnt_reach", 64'(m_cnt), 64'(v));
  endtask

  task automatic fill_rand();
    for (int i = 0; i < REG_N; i++) regs[i] = ($urandom_range(3) == 0) ? '0 : $urandom;
    for (int i = 0; i < MEM_N; i++) mem[i]  = ($urandom_range(3) == 0) ? '0 : $urandom;
  endtask

  initial begin
    int n;
    dif.out_ready = 1'b1;
    for (int i = 0; i < REG_N; i++) regs[i] = DATA_W'(i);
    for (int i = 0; i < MEM_N; i++) mem[i]  = DATA_W'(100 + i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // known pattern, header timestamp 10, ready held high
    wait_cnt(10);
    pulse_start();
    wait_idle("t1_done");

    // ready toggling 1-0-1 through the dump
    fill_rand();
    rmode = 1;
    pulse_start();
    wait_idle("t2_done");

    // start during a dump sets the sticky overrun
    rmode = 0;
    pulse_start();
    repeat (4) step();
    pulse_start();
    wait_idle("t3_done");
    repeat (3) step();
    chk("ovr_sticky", 64'(overrun), 64'(1));

    // start held high: back-to-back dump taken on the trailer handshake
    start = 1'b1;
    repeat (DUMP_CYC + 3) step();
    start = 1'b0;
    wait_idle("b2b_done");

    // reset in the middle of the memory walk
    fill_rand();
    rmode = 2;
    pulse_start();
    n = 0;
    while (!(dif.rd_sel && dif.rd_addr == 8'd7) && n < 1000) begin step(); n++; end
    chk("reach_mem7", 64'(n < 1000), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ovr", 64'(overrun), 64'(0));
    pulse_start();
    wait_idle("t4_done");

    // counter wrap in the header timestamp
    rmode = 0;
    wait_cnt(TSM - 1);
    pulse_start();
    wait_idle("t6_a");
    pulse_start();
    wait_idle("t6_b");

    for (int k = 0; k < 6; k++) begin
      fill_rand();
      rmode = $urandom_range(2);
      pulse_start();
      repeat ($urandom_range(40)) step();
      if ($urandom_range(1) == 1) pulse_start();
      wait_idle("rand_done");
      repeat ($urandom_range(5)) step();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "bench timeout");
  end

endmodule
